// File: rtl/fifo_v3_pkg.sv
// Shared helpers for fifo_v3: pointer width derivation.
package fifo_v3_pkg;

    // Pointer width; a single-entry or pass-through FIFO still carries a 1-bit pointer.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through and a DEPTH==0 pass-through mode.
// Used to hold transaction IDs between address and response handshakes.
module fifo_v3
    import fifo_v3_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = addr_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  clr_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    logic unused_testmode;
    assign unused_testmode = testmode_i;

    if (ADDR_DEPTH != addr_width(DEPTH)) begin : g_bad_addr_depth
        $error("fifo_v3: ADDR_DEPTH is derived from DEPTH and must not be overridden");
    end

    if (DEPTH == 0) begin : g_pass
        // No storage: the consumer sees the producer directly.
        logic unused_pass;
        assign unused_pass = ^{clk_i, rst_ni, flush_i, clr_i};

        assign data_o  = data_i;
        assign empty_o = ~push_i;
        assign full_o  = ~pop_i;
        assign usage_o = '0;
    end else begin : g_fifo
        localparam logic [ADDR_DEPTH:0]   DEPTH_CNT = (ADDR_DEPTH+1)'(DEPTH);
        localparam logic [ADDR_DEPTH-1:0] LAST_PTR  = ADDR_DEPTH'(DEPTH - 1);

        logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
        logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
        logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
        logic                  push_en;
        dtype                  mem_q [DEPTH];

        assign usage_o = cnt_q[ADDR_DEPTH-1:0];

        // Next-state and flag logic; explicit wrap compare supports non-power-of-2 DEPTH.
        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            cnt_d    = cnt_q;
            push_en  = 1'b0;
            data_o   = mem_q[rd_ptr_q];
            full_o   = (cnt_q == DEPTH_CNT);
            empty_o  = (cnt_q == '0) & ~(FALL_THROUGH & push_i);

            if (push_i && !full_o) begin
                push_en  = 1'b1;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
                cnt_d    = cnt_q + 1'b1;
            end

            if (pop_i && !empty_o) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
                cnt_d    = cnt_d - 1'b1;
            end

            // Empty fall-through: the item bypasses storage, and is consumed outright if popped.
            if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
                data_o = data_i;
                if (pop_i) begin
                    push_en  = 1'b0;
                    rd_ptr_d = rd_ptr_q;
                    wr_ptr_d = wr_ptr_q;
                    cnt_d    = cnt_q;
                end
            end

            if (flush_i || clr_i) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                cnt_d    = '0;
                push_en  = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mem_q <= '{default: '0};
            end else if (push_en) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end

        // Misuse by the surrounding handshake logic; the request is dropped.
        assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
            else $warning("fifo_v3: push while full dropped");
        assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
            else $warning("fifo_v3: pop while empty ignored");
    end

endmodule

// File: tb/tb_fifo_v3.sv
// Directed scoreboard bench for fifo_v3: depth 4, depth 3, fall-through and pass-through.
module tb_fifo_v3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Depth 4, registered output
    logic       push4, pop4, flush4, clr4, full4, empty4;
    logic [7:0] data4, dout4;
    logic [1:0] usage4;
    // Depth 3, non-power-of-2
    logic       push3, pop3, full3, empty3;
    logic [7:0] data3, dout3;
    logic [1:0] usage3;
    // Depth 4, fall-through
    logic       pushf, popf, fullf, emptyf;
    logic [7:0] dataf, doutf;
    logic [1:0] usagef;
    // Depth 0, pass-through
    logic       pushp, popp, fullp, emptyp;
    logic [7:0] datap, doutp;
    logic [0:0] usagep;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] q4[$];
    logic [7:0] q3[$];

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush4), .clr_i(clr4), .testmode_i(1'b0),
        .full_o(full4), .empty_o(empty4), .usage_o(usage4),
        .data_i(data4), .push_i(push4), .data_o(dout4), .pop_i(pop4)
    );

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .clr_i(1'b0), .testmode_i(1'b0),
        .full_o(full3), .empty_o(empty3), .usage_o(usage3),
        .data_i(data3), .push_i(push3), .data_o(dout3), .pop_i(pop3)
    );

    fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .clr_i(1'b0), .testmode_i(1'b0),
        .full_o(fullf), .empty_o(emptyf), .usage_o(usagef),
        .data_i(dataf), .push_i(pushf), .data_o(doutf), .pop_i(popf)
    );

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_pt (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .clr_i(1'b0), .testmode_i(1'b0),
        .full_o(fullp), .empty_o(emptyp), .usage_o(usagep),
        .data_i(datap), .push_i(pushp), .data_o(doutp), .pop_i(popp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pushed;
        int cnt3;
        logic do_push, do_pop;

        rst_n = 1'b0;
        {push4, pop4, flush4, clr4, data4} = '0;
        {push3, pop3, data3} = '0;
        {pushf, popf, dataf} = '0;
        {pushp, popp, datap} = '0;
        #2;
        chk("rst_empty4", empty4, 1);
        chk("rst_full4", full4, 0);
        chk("rst_usage4", usage4, 0);
        chk("rst_emptyf", emptyf, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Fill depth 4, then a dropped 5th push
        for (int i = 0; i < 4; i++) begin
            push4 = 1'b1;
            data4 = 8'hA0 + 8'(i);
            q4.push_back(data4);
            tick();
        end
        data4 = 8'hEE;
        #1;
        chk("full4_after4", full4, 1);
        chk("usage4_full_wraps", usage4, 0);
        tick();
        push4 = 1'b0;
        #1;
        chk("full4_after_drop", full4, 1);
        for (int i = 0; i < 4; i++) begin
            chk("d4_not_empty", empty4, 0);
            chk("d4_pop_order", dout4, q4.pop_front());
            pop4 = 1'b1;
            tick();
        end
        pop4 = 1'b0;
        #1;
        chk("d4_empty_after_drain", empty4, 1);

        // Simultaneous push and pop at count 2
        for (int i = 0; i < 2; i++) begin
            push4 = 1'b1;
            data4 = 8'h10 + 8'(i);
            q4.push_back(data4);
            tick();
        end
        data4 = 8'h12;
        pop4  = 1'b1;
        #1;
        chk("pp_head_before", dout4, q4.pop_front());
        q4.push_back(data4);
        tick();
        push4 = 1'b0;
        pop4  = 1'b0;
        #1;
        chk("pp_usage", usage4, 2);
        chk("pp_head_after", dout4, q4[0]);

        // Flush at count 3 with a concurrent push
        push4 = 1'b1;
        data4 = 8'h13;
        q4.push_back(data4);
        tick();
        #1;
        chk("pre_flush_usage", usage4, 3);
        flush4 = 1'b1;
        data4  = 8'hEE;
        tick();
        flush4 = 1'b0;
        push4  = 1'b0;
        q4.delete();
        #1;
        chk("flush_empty", empty4, 1);
        chk("flush_usage", usage4, 0);
        push4 = 1'b1;
        data4 = 8'h77;
        q4.push_back(data4);
        tick();
        push4 = 1'b0;
        #1;
        chk("post_flush_head", dout4, q4[0]);
        chk("post_flush_usage", usage4, 1);

        // clr_i behaves like flush_i
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        q4.delete();
        #1;
        chk("clr_empty", empty4, 1);
        chk("clr_usage", usage4, 0);

        // Depth 3: interleaved traffic of 10 items
        pushed = 0;
        cnt3   = 0;
        for (int c = 0; c < 60 && (pushed < 10 || cnt3 > 0); c++) begin
            do_push = (pushed < 10) && (c % 4 != 3) && (cnt3 < 3);
            do_pop  = (cnt3 > 0) && ((c % 3 == 2) || (pushed == 10));
            push3 = do_push;
            pop3  = do_pop;
            data3 = 8'h30 + 8'(pushed);
            #1;
            chk("d3_usage", usage3, cnt3);
            chk("d3_full", full3, cnt3 == 3);
            if (cnt3 > 0) chk("d3_head", dout3, q3[0]);
            if (do_push) begin
                q3.push_back(data3);
                pushed++;
            end
            if (do_pop) void'(q3.pop_front());
            cnt3 = q3.size();
            tick();
        end
        push3 = 1'b0;
        pop3  = 1'b0;
        #1;
        chk("d3_all_pushed", pushed, 10);
        chk("d3_drained", empty3, 1);

        // Fall-through: push and pop together on empty
        pushf = 1'b1;
        popf  = 1'b1;
        dataf = 8'h5A;
        #1;
        chk("ft_bypass_data", doutf, 8'h5A);
        chk("ft_bypass_empty", emptyf, 0);
        tick();
        pushf = 1'b0;
        popf  = 1'b0;
        #1;
        chk("ft_bypass_usage", usagef, 0);
        chk("ft_bypass_idle_empty", emptyf, 1);
        pushf = 1'b1;
        dataf = 8'h3C;
        #1;
        chk("ft_push_data", doutf, 8'h3C);
        tick();
        pushf = 1'b0;
        #1;
        chk("ft_stored_usage", usagef, 1);
        chk("ft_stored_data", doutf, 8'h3C);
        popf = 1'b1;
        tick();
        popf = 1'b0;
        #1;
        chk("ft_drained", emptyf, 1);

        // Pass-through
        pushp = 1'b1;
        datap = 8'h11;
        #1;
        chk("pt_data", doutp, 8'h11);
        chk("pt_empty_push", emptyp, 0);
        chk("pt_full_nopop", fullp, 1);
        chk("pt_usage", usagep, 0);
        pushp = 1'b0;
        popp  = 1'b1;
        #1;
        chk("pt_empty_idle", emptyp, 1);
        chk("pt_full_pop", fullp, 0);
        popp = 1'b0;

        // Asynchronous reset mid-stream at count 2
        for (int i = 0; i < 2; i++) begin
            push4 = 1'b1;
            data4 = 8'h91 + 8'(i);
            tick();
        end
        push4 = 1'b0;
        #1;
        chk("pre_rst_usage", usage4, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_empty", empty4, 1);
        chk("midrst_usage", usage4, 0);
        chk("midrst_full", full4, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        push4 = 1'b1;
        data4 = 8'hA5;
        q4.push_back(data4);
        tick();
        push4 = 1'b0;
        #1;
        chk("postrst_head", dout4, q4.pop_front());
        chk("postrst_empty", empty4, 0);
        chk("postrst_usage", usage4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
